biu_bus_sequencer: RTL and testbench

- Bus-cycle sequencer and arbiter for the 8086 bus interface unit.
- Shares the segment:offset address generation circuit and the external bus between two requesters: the instruction prefetcher (CS:fetch_ip) and execution-unit (EU) data accesses.
- Runs the T1-T2-T3-(TW)-T4 bus cycle, pushes fetched words into the instruction queue, and handles queue flush on jumps.

---
 rtl/biu_bus_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_biu_bus_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/biu_bus_sequencer.sv
// ---------------------------------------------------------------------------
// biu_bus_sequencer
// Bus-cycle sequencer/arbiter for the 8086 BIU. Arbitrates the shared
// address generator and external bus between the instruction prefetcher
// (cs:fetch_ip) and EU data accesses, runs T1-T2-T3-(TW)-T4 and pushes
// fetched words into the instruction queue.
//
// Optional feature macro: BIU_WAIT_TIMEOUT_EN (TW timeout abort + bus_err).
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   cs, ip_load, ip_load_val   prefetch segment, jump/flush pulse, new offset
//   queue_free                 free bytes in the instruction queue
//   eu_req/we/seg/off/wdata    EU access request (held until eu_ack)
//   eu_ack, eu_rdata           EU completion pulse and read data
//   agc_segment/offset/phys    address generator interface (phys is comb.)
//   bus_addr/ale/rd/wr/wdata   external bus outputs
//   bus_rdata, bus_ready       external bus inputs
//   q_push, q_data, q_flush    instruction queue interface
//   bus_err                    timeout abort pulse (0 unless feature enabled)
// ---------------------------------------------------------------------------
module biu_bus_sequencer #(
    parameter int unsigned QUEUE_DEPTH = 6
`ifdef BIU_WAIT_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cs,
    input  logic        ip_load,
    input  logic [15:0] ip_load_val,
    input  logic [2:0]  queue_free,
    input  logic        eu_req,
    input  logic        eu_we,
    input  logic [15:0] eu_seg,
    input  logic [15:0] eu_off,
    input  logic [15:0] eu_wdata,
    output logic        eu_ack,
    output logic [15:0] eu_rdata,
    output logic [15:0] agc_segment,
    output logic [15:0] agc_offset,
    input  logic [19:0] agc_phys,
    output logic [19:0] bus_addr,
    output logic        bus_ale,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [15:0] bus_wdata,
    input  logic [15:0] bus_rdata,
    input  logic        bus_ready,
    output logic        q_push,
    output logic [15:0] q_data,
    output logic        q_flush,
    output logic        bus_err
);

    localparam int unsigned PF_BYTES = 2;

    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4} state_t;

    state_t      r_state;
    logic        r_own_eu, r_we, r_kill;
    logic [15:0] r_seg, r_off, r_wdata_l, r_fetch_ip;
    logic [19:0] r_bus_addr;
    logic        r_ale, r_rd, r_wr, r_eu_ack, r_q_push, r_q_flush, r_bus_err;
    logic [15:0] r_bus_wdata, r_eu_rdata, r_q_data;

    logic        w_can_fetch, w_grant_eu, w_grant_pf, w_abort;

    // Out-of-range free counts (above the queue size) are treated as no room.
    assign w_can_fetch = (32'(queue_free) >= PF_BYTES) && (32'(queue_free) <= QUEUE_DEPTH);
    assign w_grant_eu  = (r_state == S_IDLE) && eu_req;
    assign w_grant_pf  = (r_state == S_IDLE) && !eu_req && w_can_fetch && !ip_load;

    // The IDLE cycle is the grant cycle, so the EU address must already be on
    // the generator there for bus_addr to capture it; afterwards hold the owner.
    always_comb begin
        agc_segment = r_seg;
        agc_offset  = r_off;
        if (r_state == S_IDLE) begin
            agc_segment = eu_req ? eu_seg : cs;
            agc_offset  = eu_req ? eu_off : r_fetch_ip;
        end
    end

`ifdef BIU_WAIT_TIMEOUT_EN
    localparam int unsigned TW_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW_CNT_W-1:0] r_tw_cnt;

    // Counts TW cycles of the current bus cycle; abort on the last allowed one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_tw_cnt <= '0;
        else if (r_state == S_TW)   r_tw_cnt <= r_tw_cnt + TW_CNT_W'(1);
        else                        r_tw_cnt <= '0;
    end

    assign w_abort = (r_state == S_TW) && !bus_ready &&
                     (r_tw_cnt == TW_CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_abort = 1'b0;
`endif

    // Bus-cycle FSM with registered bus/queue/EU outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_own_eu    <= 1'b0;
            r_we        <= 1'b0;
            r_kill      <= 1'b0;
            r_seg       <= '0;
            r_off       <= '0;
            r_wdata_l   <= '0;
            r_fetch_ip  <= '0;
            r_bus_addr  <= '0;
            r_ale       <= 1'b0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_bus_wdata <= '0;
            r_eu_ack    <= 1'b0;
            r_eu_rdata  <= '0;
            r_q_push    <= 1'b0;
            r_q_data    <= '0;
            r_q_flush   <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_ale      <= 1'b0;
            r_eu_ack   <= 1'b0;
            r_eu_rdata <= '0;
            r_q_push   <= 1'b0;
            r_q_flush  <= ip_load;
            r_bus_err  <= 1'b0;

            // A jump always wins over the post-fetch increment.
            if (ip_load)
                r_fetch_ip <= ip_load_val;
            else if (r_state == S_T4 && !r_own_eu && !r_kill)
                r_fetch_ip <= r_fetch_ip + 16'd2;

            // A jump seen while a prefetch is in flight discards its data.
            if (r_state == S_IDLE)
                r_kill <= 1'b0;
            else if (ip_load)
                r_kill <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_grant_eu || w_grant_pf) begin
                        r_own_eu   <= w_grant_eu;
                        r_we       <= w_grant_eu && eu_we;
                        r_seg      <= agc_segment;
                        r_off      <= agc_offset;
                        r_wdata_l  <= eu_wdata;
                        r_bus_addr <= agc_phys;
                        r_ale      <= 1'b1;
                        r_state    <= S_T1;
                    end
                end
                S_T1: begin
                    if (r_we) begin
                        r_wr        <= 1'b1;
                        r_bus_wdata <= r_wdata_l;
                    end else begin
                        r_rd <= 1'b1;
                    end
                    r_state <= S_T2;
                end
                S_T2: r_state <= S_T3;
                S_T3, S_TW: begin
                    if (bus_ready) begin
                        r_rd    <= 1'b0;
                        r_wr    <= 1'b0;
                        r_state <= S_T4;
                        if (r_own_eu) begin
                            r_eu_ack   <= 1'b1;
                            r_eu_rdata <= r_we ? 16'h0000 : bus_rdata;
                        end else if (!r_kill && !ip_load) begin
                            r_q_push <= 1'b1;
                            r_q_data <= bus_rdata;
                        end
                    end else if (w_abort) begin
                        r_rd      <= 1'b0;
                        r_wr      <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_eu_ack  <= r_own_eu;
                        r_eu_rdata <= r_own_eu ? 16'hFFFF : 16'h0000;
                        r_state   <= S_IDLE;
                    end else begin
                        r_state <= S_TW;
                    end
                end
                S_T4:    r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus_addr  = r_bus_addr;
    assign bus_ale   = r_ale;
    assign bus_rd    = r_rd;
    assign bus_wr    = r_wr;
    assign bus_wdata = r_bus_wdata;
    assign eu_ack    = r_eu_ack;
    assign eu_rdata  = r_eu_rdata;
    assign q_push    = r_q_push;
    assign q_data    = r_q_data;
    assign q_flush   = r_q_flush;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_biu_bus_sequencer.sv
// ---------------------------------------------------------------------------
// tb_biu_bus_sequencer
// Directed bench for biu_bus_sequencer. Models the address generator as
// seg*16 + off (20-bit wrap) and checks outputs 1 time unit after each edge.
// ---------------------------------------------------------------------------
module tb_biu_bus_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cs, ip_load_val, eu_seg, eu_off, eu_wdata, bus_rdata;
    logic        ip_load, eu_req, eu_we, bus_ready;
    logic [2:0]  queue_free;
    logic        eu_ack, bus_ale, bus_rd, bus_wr, q_push, q_flush, bus_err;
    logic [15:0] eu_rdata, agc_segment, agc_offset, bus_wdata, q_data;
    logic [19:0] agc_phys, bus_addr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign agc_phys = {agc_segment, 4'h0} + {4'h0, agc_offset};

    biu_bus_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .ip_load(ip_load), .ip_load_val(ip_load_val),
        .queue_free(queue_free), .eu_req(eu_req), .eu_we(eu_we), .eu_seg(eu_seg),
        .eu_off(eu_off), .eu_wdata(eu_wdata), .eu_ack(eu_ack), .eu_rdata(eu_rdata),
        .agc_segment(agc_segment), .agc_offset(agc_offset), .agc_phys(agc_phys),
        .bus_addr(bus_addr), .bus_ale(bus_ale), .bus_rd(bus_rd), .bus_wr(bus_wr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
        .q_push(q_push), .q_data(q_data), .q_flush(q_flush), .bus_err(bus_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // ---- reset, first prefetch ----
        rst_n = 1'b0; cs = 16'h1000; ip_load = 1'b0; ip_load_val = '0;
        queue_free = 3'd6; eu_req = 1'b0; eu_we = 1'b0; eu_seg = '0; eu_off = '0;
        eu_wdata = '0; bus_rdata = 16'hB8A5; bus_ready = 1'b1;
        step(); step();
        chk("rst_bus_addr", 32'(bus_addr), 32'h0);
        chk("rst_ale", 32'(bus_ale), 32'h0);
        chk("rst_rd", 32'(bus_rd), 32'h0);
        chk("rst_wr", 32'(bus_wr), 32'h0);
        chk("rst_q_push", 32'(q_push), 32'h0);
        chk("rst_eu_ack", 32'(eu_ack), 32'h0);
        chk("rst_q_flush", 32'(q_flush), 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        chk("rst_agc_off", 32'(agc_offset), 32'h0);
        rst_n = 1'b1;                       // grant cycle
        step();                             // T1
        chk("pf1_ale", 32'(bus_ale), 32'h1);
        chk("pf1_addr", 32'(bus_addr), 32'h10000);
        chk("pf1_rd_t1", 32'(bus_rd), 32'h0);
        step();                             // T2
        chk("pf1_ale_t2", 32'(bus_ale), 32'h0);
        chk("pf1_rd_t2", 32'(bus_rd), 32'h1);
        step();                             // T3
        chk("pf1_rd_t3", 32'(bus_rd), 32'h1);
        chk("pf1_push_t3", 32'(q_push), 32'h0);
        queue_free = 3'd1;
        step();                             // T4
        chk("pf1_push", 32'(q_push), 32'h1);
        chk("pf1_qdata", 32'(q_data), 32'hB8A5);
        chk("pf1_rd_t4", 32'(bus_rd), 32'h0);
        step();                             // IDLE
        chk("pf1_push_off", 32'(q_push), 32'h0);
        chk("pf2_agc_off", 32'(agc_offset), 32'h0002);

        // ---- queue_free=1: no bus activity ----
        step(); step();
        chk("qf1_ale", 32'(bus_ale), 32'h0);
        chk("qf1_rd", 32'(bus_rd), 32'h0);
        chk("qf1_addr", 32'(bus_addr), 32'h10000);
        queue_free = 3'd6;
        step();                             // T1
        chk("pf2_addr", 32'(bus_addr), 32'h10002);
        chk("pf2_ale", 32'(bus_ale), 32'h1);
        queue_free = 3'd1;
        step(); step(); step();             // T2, T3, T4
        chk("pf2_push", 32'(q_push), 32'h1);
        step();                             // IDLE, fetch_ip = 0004

        // ---- EU read wins over prefetch ----
        queue_free = 3'd6; bus_rdata = 16'h5A5A;
        eu_req = 1'b1; eu_we = 1'b0; eu_seg = 16'h2000; eu_off = 16'h0010;
        #1;
        chk("eur_agc_seg", 32'(agc_segment), 32'h2000);
        step();                             // T1
        chk("eur_addr", 32'(bus_addr), 32'h20010);
        step();                             // T2
        chk("eur_rd", 32'(bus_rd), 32'h1);
        step(); step();                     // T3, T4
        chk("eur_ack", 32'(eu_ack), 32'h1);
        chk("eur_rdata", 32'(eu_rdata), 32'h5A5A);
        chk("eur_no_push", 32'(q_push), 32'h0);
        eu_req = 1'b0; queue_free = 3'd1;
        step();                             // IDLE
        chk("eur_ack_off", 32'(eu_ack), 32'h0);

        // ---- EU write with 3 wait states ----
        eu_req = 1'b1; eu_we = 1'b1; eu_off = 16'h0020; eu_wdata = 16'h1234; bus_ready = 1'b0;
        step();                             // T1
        chk("euw_addr", 32'(bus_addr), 32'h20020);
        step();                             // T2
        chk("euw_wr_t2", 32'(bus_wr), 32'h1);
        chk("euw_wdata", 32'(bus_wdata), 32'h1234);
        chk("euw_rd", 32'(bus_rd), 32'h0);
        for (int i = 0; i < 4; i++) begin   // T3, TW1, TW2, TW3
            step();
            chk("euw_wr_hold", 32'(bus_wr), 32'h1);
            chk("euw_no_ack", 32'(eu_ack), 32'h0);
        end
        bus_ready = 1'b1;
        step();                             // T4
        chk("euw_ack", 32'(eu_ack), 32'h1);
        chk("euw_rdata", 32'(eu_rdata), 32'h0);
        chk("euw_wr_t4", 32'(bus_wr), 32'h0);
        eu_req = 1'b0; eu_we = 1'b0;
        step();                             // IDLE

        // ---- ip_load during prefetch T3 ----
        queue_free = 3'd6; bus_rdata = 16'hB8A5;
        step();                             // T1
        chk("jmp_addr", 32'(bus_addr), 32'h10004);
        queue_free = 3'd1;
        step(); step();                     // T2, T3
        ip_load = 1'b1; ip_load_val = 16'h0100;
        step();                             // T4
        ip_load = 1'b0;
        chk("jmp_flush", 32'(q_flush), 32'h1);
        chk("jmp_no_push", 32'(q_push), 32'h0);
        step();                             // IDLE
        chk("jmp_flush_off", 32'(q_flush), 32'h0);
        chk("jmp_agc_off", 32'(agc_offset), 32'h0100);
        queue_free = 3'd6;
        step();                             // T1
        chk("jmp_next_addr", 32'(bus_addr), 32'h10100);
        queue_free = 3'd1;
        step(); step(); step();             // T2, T3, T4
        chk("jmp_next_push", 32'(q_push), 32'h1);
        step();                             // IDLE

        // ---- fetch_ip wrap ----
        ip_load = 1'b1; ip_load_val = 16'hFFFE; cs = 16'hF000;
        step();
        ip_load = 1'b0;
        chk("wrap_flush", 32'(q_flush), 32'h1);
        queue_free = 3'd6;
        step();                             // T1
        chk("wrap_addr", 32'(bus_addr), 32'hFFFFE);
        queue_free = 3'd1;
        step(); step(); step();             // T2, T3, T4
        chk("wrap_push", 32'(q_push), 32'h1);
        step();                             // IDLE
        chk("wrap_ip", 32'(agc_offset), 32'h0000);
        queue_free = 3'd6;
        step();                             // T1
        chk("wrap_next_addr", 32'(bus_addr), 32'hF0000);
        queue_free = 3'd1;
        step(); step(); step(); step();     // T2, T3, T4, IDLE

`ifdef BIU_WAIT_TIMEOUT_EN
        // ---- wait-state timeout on EU read ----
        eu_req = 1'b1; eu_we = 1'b0; eu_seg = 16'h2000; eu_off = 16'h0030; bus_ready = 1'b0;
        step(); step(); step();             // T1, T2, T3
        for (int i = 0; i < 16; i++) step(); // TW1..TW16
        chk("to_no_err_tw16", 32'(bus_err), 32'h0);
        chk("to_rd_tw16", 32'(bus_rd), 32'h1);
        step();
        chk("to_bus_err", 32'(bus_err), 32'h1);
        chk("to_ack", 32'(eu_ack), 32'h1);
        chk("to_rdata", 32'(eu_rdata), 32'hFFFF);
        chk("to_rd_drop", 32'(bus_rd), 32'h0);
        eu_req = 1'b0; bus_ready = 1'b1;
        step();
        chk("to_err_off", 32'(bus_err), 32'h0);
`endif

        // ---- reset in the middle of a cycle ----
        cs = 16'h1000; queue_free = 3'd6;
        step();                             // T1
        queue_free = 3'd1;
        step();                             // T2
        chk("mid_rd_before", 32'(bus_rd), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rd_drop", 32'(bus_rd), 32'h0);
        chk("mid_addr_clr", 32'(bus_addr), 32'h0);
        step();
        rst_n = 1'b1;
        step(); step(); step();
        chk("mid_no_push", 32'(q_push), 32'h0);
        chk("mid_no_rd", 32'(bus_rd), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
